hazard_ctrl: RTL and testbench

//  Pipeline hazard controller for the 5-stage core. Sequences the IF/ID/EX/MEM/WB registers around the

---
 rtl/hazard_ctrl_pkg.sv | 33 +++
 rtl/hazard_ctrl_fwd_unit.sv | 35 +++
 rtl/hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_hazard_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: forwarding-select codes,
// FSM state codes and the bundle of pipeline-sequencing controls.
package hazard_ctrl_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MEMWAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_bubble;
    logic ex_mem_stall;
  } ctrl_t;

  // A producer feeds a consumer only if it writes a register other than x0.
  function automatic logic rd_match(input logic [REG_W-1:0] rd,
                                    input logic             we,
                                    input logic [REG_W-1:0] rs);
    return we && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Combinational operand forwarding for EX and write-through bypass for the
// ID-stage register-file read ports.
module hazard_ctrl_fwd_unit
  import hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] ex_rs1_addr,
  input  logic [REG_W-1:0] ex_rs2_addr,
  input  logic [REG_W-1:0] id_rs1_addr,
  input  logic [REG_W-1:0] id_rs2_addr,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] mem_rd_addr,
  input  logic             mem_regWrite,
  input  logic [REG_W-1:0] wb_rd_addr,
  input  logic             wb_regWrite,
  output fwd_sel_e         fwd_a,
  output fwd_sel_e         fwd_b,
  output logic             id_byp_rs1,
  output logic             id_byp_rs2
);

  // The younger producer (EX/MEM) holds the newer value, so it wins over MEM/WB.
  function automatic fwd_sel_e pick(input logic [REG_W-1:0] rs);
    if (rd_match(mem_rd_addr, mem_regWrite, rs)) return FWD_EXMEM;
    if (rd_match(wb_rd_addr, wb_regWrite, rs))   return FWD_MEMWB;
    return FWD_REG;
  endfunction

  assign fwd_a = pick(ex_rs1_addr);
  assign fwd_b = pick(ex_rs2_addr);

  assign id_byp_rs1 = id_use_rs1 && rd_match(wb_rd_addr, wb_regWrite, id_rs1_addr);
  assign id_byp_rs2 = id_use_rs2 && rd_match(wb_rd_addr, wb_regWrite, id_rs2_addr);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, EX branch flushes, data-memory
// waits with timeout detection, forwarding/bypass selects and perf counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [REG_W-1:0] id_rs1_addr,
  input  logic [REG_W-1:0] id_rs2_addr,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rs1_addr,
  input  logic [REG_W-1:0] ex_rs2_addr,
  input  logic [REG_W-1:0] ex_rd_addr,
  input  logic             ex_regWrite,
  input  logic             ex_MemRead,
  input  logic [REG_W-1:0] mem_rd_addr,
  input  logic             mem_regWrite,
  input  logic [REG_W-1:0] wb_rd_addr,
  input  logic             wb_regWrite,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_stall,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             id_byp_rs1,
  output logic             id_byp_rs2,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int                  TIMER_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TIMER_W-1:0]  TIMER_MAX = TIMER_W'(MEM_TIMEOUT);

  state_e             state;
  logic [TIMER_W-1:0] timer;
  ctrl_t              ctrl;
  fwd_sel_e           fwd_a_raw, fwd_b_raw;
  logic               byp1_raw, byp2_raw;
  logic               load_use;

  hazard_ctrl_fwd_unit u_fwd (
    .ex_rs1_addr  (ex_rs1_addr),
    .ex_rs2_addr  (ex_rs2_addr),
    .id_rs1_addr  (id_rs1_addr),
    .id_rs2_addr  (id_rs2_addr),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .mem_rd_addr  (mem_rd_addr),
    .mem_regWrite (mem_regWrite),
    .wb_rd_addr   (wb_rd_addr),
    .wb_regWrite  (wb_regWrite),
    .fwd_a        (fwd_a_raw),
    .fwd_b        (fwd_b_raw),
    .id_byp_rs1   (byp1_raw),
    .id_byp_rs2   (byp2_raw)
  );

  // A load always writes rd, so ex_regWrite only confirms what ex_MemRead implies.
  assign load_use = ex_MemRead && ex_regWrite &&
                    ((id_use_rs1 && rd_match(ex_rd_addr, 1'b1, id_rs1_addr)) ||
                     (id_use_rs2 && rd_match(ex_rd_addr, 1'b1, id_rs2_addr)));

  always_comb begin
    // NOTE: default every output first so no path through the ifs infers a latch.
    ctrl = '0;
    if (!rstn) begin
      ctrl = '0;
    end else if (mem_busy) begin
      // The whole pipe freezes; a taken branch in EX stays put and flushes later.
      ctrl.pc_stall     = 1'b1;
      ctrl.if_id_stall  = 1'b1;
      ctrl.ex_mem_stall = 1'b1;
    end else if (ex_branch_taken) begin
      // The ID instruction is wrong-path, so any load-use hazard it has is moot.
      ctrl.if_id_flush  = 1'b1;
      ctrl.id_ex_bubble = 1'b1;
    end else if (load_use) begin
      ctrl.pc_stall     = 1'b1;
      ctrl.if_id_stall  = 1'b1;
      ctrl.id_ex_bubble = 1'b1;
    end
  end

  assign pc_stall     = ctrl.pc_stall;
  assign if_id_stall  = ctrl.if_id_stall;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_bubble = ctrl.id_ex_bubble;
  assign ex_mem_stall = ctrl.ex_mem_stall;
  assign fwd_a        = rstn ? fwd_a_raw : FWD_REG;
  assign fwd_b        = rstn ? fwd_b_raw : FWD_REG;
  assign id_byp_rs1   = rstn && byp1_raw;
  assign id_byp_rs2   = rstn && byp2_raw;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_RUN;
      timer       <= '0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      case (state)
        ST_RUN: begin
          if (mem_busy) state <= ST_MEMWAIT;
        end
        ST_MEMWAIT: begin
          if (!mem_busy) begin
            state <= ST_RUN;
            timer <= '0;
          end else if (timer != TIMER_MAX) begin
            timer <= timer + TIMER_W'(1);
            if (timer == TIMER_MAX - TIMER_W'(1)) mem_timeout <= 1'b1;
          end
        end
      endcase
      if (ctrl.pc_stall)    stall_cnt <= stall_cnt + CNT_W'(1);
      if (ctrl.if_id_flush) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed plus randomized checks of hazard_ctrl against a rule-level model
// of stalls, flushes, forwarding, bypass, timeout and counters.
module tb_hazard_ctrl;

  localparam int TMO   = 4;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rstn;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic [4:0] mem_rd_addr, wb_rd_addr;
  logic id_use_rs1, id_use_rs2, ex_regWrite, ex_MemRead, mem_regWrite, wb_regWrite;
  logic ex_branch_taken, mem_busy;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_mem_stall;
  logic [1:0] fwd_a, fwd_b;
  logic id_byp_rs1, id_byp_rs2, mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_pass = 0;
  int n_total = 0;

  // Model state: counters as plain integers, length of the current mem_busy run.
  int m_stall, m_flush, m_busy_run;
  bit m_timeout;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
    .ex_regWrite(ex_regWrite), .ex_MemRead(ex_MemRead),
    .mem_rd_addr(mem_rd_addr), .mem_regWrite(mem_regWrite),
    .wb_rd_addr(wb_rd_addr), .wb_regWrite(wb_regWrite),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .ex_mem_stall(ex_mem_stall),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .id_byp_rs1(id_byp_rs1), .id_byp_rs2(id_byp_rs2),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic bit writes(input logic [4:0] rd, input logic we, input logic [4:0] rs);
    return we && rd != 5'd0 && rd == rs;
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
    if (writes(mem_rd_addr, mem_regWrite, rs)) return 2'b01;
    if (writes(wb_rd_addr, wb_regWrite, rs))   return 2'b10;
    return 2'b00;
  endfunction

  task automatic idle();
    {id_rs1_addr, id_rs2_addr, ex_rs1_addr, ex_rs2_addr, ex_rd_addr} = '0;
    {mem_rd_addr, wb_rd_addr} = '0;
    {id_use_rs1, id_use_rs2, ex_regWrite, ex_MemRead, mem_regWrite, wb_regWrite} = '0;
    ex_branch_taken = 1'b0;
    mem_busy = 1'b0;
  endtask

  // One clock: compare all outputs mid-cycle, then advance the model across the edge.
  task automatic cycle(input string tag);
    bit lu, e_stall, e_flush, e_bubble;
    @(negedge clk);
    lu = ex_MemRead && ex_rd_addr != 5'd0 &&
         ((id_use_rs1 && ex_rd_addr == id_rs1_addr) || (id_use_rs2 && ex_rd_addr == id_rs2_addr));
    e_stall  = mem_busy || (!ex_branch_taken && lu);
    e_flush  = !mem_busy && ex_branch_taken;
    e_bubble = !mem_busy && (ex_branch_taken || lu);
    check({tag, ".pc_stall"},     32'(pc_stall),     32'(e_stall));
    check({tag, ".if_id_stall"},  32'(if_id_stall),  32'(e_stall));
    check({tag, ".if_id_flush"},  32'(if_id_flush),  32'(e_flush));
    check({tag, ".id_ex_bubble"}, 32'(id_ex_bubble), 32'(e_bubble));
    check({tag, ".ex_mem_stall"}, 32'(ex_mem_stall), 32'(mem_busy));
    check({tag, ".fwd_a"},        32'(fwd_a),        32'(exp_fwd(ex_rs1_addr)));
    check({tag, ".fwd_b"},        32'(fwd_b),        32'(exp_fwd(ex_rs2_addr)));
    check({tag, ".byp1"}, 32'(id_byp_rs1), 32'(id_use_rs1 && writes(wb_rd_addr, wb_regWrite, id_rs1_addr)));
    check({tag, ".byp2"}, 32'(id_byp_rs2), 32'(id_use_rs2 && writes(wb_rd_addr, wb_regWrite, id_rs2_addr)));
    check({tag, ".mem_timeout"}, 32'(mem_timeout), 32'(m_timeout));
    check({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stall % (1 << CNT_W)));
    check({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(m_flush % (1 << CNT_W)));
    @(posedge clk);
    if (e_stall) m_stall++;
    if (e_flush) m_flush++;
    m_busy_run = mem_busy ? m_busy_run + 1 : 0;
    // First busy edge enters the wait state; each further busy edge is a waited cycle.
    if (m_busy_run - 1 >= TMO) m_timeout = 1'b1;
    #1;
  endtask

  // Assert reset with whatever inputs are live; outputs must drop immediately.
  task automatic do_reset(input string tag);
    rstn = 1'b0;
    #2;
    check({tag, ".pc_stall"},     32'(pc_stall),     32'd0);
    check({tag, ".ex_mem_stall"}, 32'(ex_mem_stall), 32'd0);
    check({tag, ".id_ex_bubble"}, 32'(id_ex_bubble), 32'd0);
    check({tag, ".if_id_flush"},  32'(if_id_flush),  32'd0);
    check({tag, ".fwd"},          32'({fwd_a, fwd_b}), 32'd0);
    check({tag, ".timeout"},      32'(mem_timeout),  32'd0);
    check({tag, ".cnts"},         32'({stall_cnt, flush_cnt}), 32'd0);
    m_stall = 0; m_flush = 0; m_busy_run = 0; m_timeout = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    idle();
    mem_busy = 1'b1;
    ex_branch_taken = 1'b1;
    do_reset("reset0");
    idle();
    cycle("idle");

    // Load-use: lw x5 in EX, add x6,x5,x1 in ID.
    ex_MemRead = 1; ex_regWrite = 1; ex_rd_addr = 5;
    id_rs1_addr = 5; id_rs2_addr = 1; id_use_rs1 = 1; id_use_rs2 = 1;
    cycle("t1_stall");
    ex_MemRead = 0; ex_regWrite = 0; ex_rd_addr = 0;
    mem_rd_addr = 5; mem_regWrite = 1;
    cycle("t1_bubble");
    ex_rs1_addr = 5; ex_rs2_addr = 1;
    mem_rd_addr = 0; mem_regWrite = 0; wb_rd_addr = 5; wb_regWrite = 1;
    id_rs1_addr = 5; id_rs2_addr = 7;
    #1 check("t1_fwd_a_wb", 32'(fwd_a), 32'd2);
    cycle("t1_fwd");

    // MEM beats WB; x0 never forwards.
    idle();
    mem_rd_addr = 3; mem_regWrite = 1; wb_rd_addr = 3; wb_regWrite = 1;
    ex_rs1_addr = 3; ex_rs2_addr = 3;
    #1 check("t2_fwd_mem", 32'(fwd_a), 32'd1);
    cycle("t2_mem");
    mem_rd_addr = 0; wb_regWrite = 0; ex_rs1_addr = 0; ex_rs2_addr = 0;
    #1 check("t2_fwd_x0", 32'(fwd_a), 32'd0);
    cycle("t2_x0");
    ex_MemRead = 1; ex_regWrite = 1; ex_rd_addr = 0; id_use_rs1 = 1;
    cycle("t2_lu_x0");

    // Branch overrides a concurrent load-use hazard.
    idle();
    ex_MemRead = 1; ex_regWrite = 1; ex_rd_addr = 9; id_rs2_addr = 9; id_use_rs2 = 1;
    ex_branch_taken = 1;
    cycle("t3_branch");
    #1 check("t3_flush_cnt", 32'(flush_cnt), 32'd1);

    // mem_busy for 5 cycles with the branch frozen in EX, flush on the 6th.
    idle();
    ex_branch_taken = 1; mem_busy = 1;
    repeat (5) cycle("t4_busy");
    mem_busy = 0;
    cycle("t4_release");
    idle();
    cycle("t4_after");

    // Long wait trips the sticky timeout.
    mem_busy = 1;
    for (int i = 0; i < 10; i++) cycle("t5_busy");
    mem_busy = 0;
    repeat (3) cycle("t5_after");
    #1 check("t5_sticky", 32'(mem_timeout), 32'd1);

    // Reset in the middle of a wait, then confirm the timer restarts from RUN.
    mem_busy = 1;
    repeat (3) cycle("t6_busy");
    do_reset("t6_reset");
    mem_busy = 0;
    cycle("t6_run");
    mem_busy = 1;
    repeat (TMO + 2) cycle("t6_rebusy");
    mem_busy = 0;
    cycle("t6_done");

    // Random traffic over a small register range to provoke matches.
    for (int i = 0; i < 1200; i++) begin
      id_rs1_addr = 5'($urandom_range(0, 3));
      id_rs2_addr = 5'($urandom_range(0, 3));
      ex_rs1_addr = 5'($urandom_range(0, 3));
      ex_rs2_addr = 5'($urandom_range(0, 3));
      ex_rd_addr  = 5'($urandom_range(0, 3));
      mem_rd_addr = 5'($urandom_range(0, 3));
      wb_rd_addr  = 5'($urandom_range(0, 3));
      id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom);
      ex_MemRead = 1'($urandom);
      ex_regWrite = ex_MemRead | 1'($urandom);
      mem_regWrite = 1'($urandom); wb_regWrite = 1'($urandom);
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      mem_busy = ($urandom_range(0, 3) == 0);
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
